// File: rtl/seq_controller.sv
// Sequencing FSM of the UART sequence calculator: computes Padovan/Moser term n and sends it as decimal ASCII.
// Optional feature macro SEQ_CTRL_PREFIX_EN prepends "P=" or "M=" to every reply.
module seq_controller #(
    parameter int W    = 32,
    parameter int NDIG = 10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cmd_ready,
    input  logic       seq_sel,
    input  logic [7:0] n_value,
    output logic       parser_clr,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_busy,
    output logic       busy,
    output logic       ovf
);
    localparam int DW = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [1:0] K_BODY = 2'd2;
    localparam logic [1:0] K_NL   = 2'd3;
`ifdef SEQ_CTRL_PREFIX_EN
    localparam logic [1:0] K_PRE0  = 2'd0;
    localparam logic [1:0] K_PRE1  = 2'd1;
    localparam logic [1:0] K_FIRST = K_PRE0;
`else
    localparam logic [1:0] K_FIRST = K_BODY;
`endif

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        LATCH   = 4'd1,
        CALC    = 4'd2,
        BCD     = 4'd3,
        EMIT    = 4'd4,
        TXWAIT1 = 4'd5,
        TXWAIT  = 4'd6,
        CLEAR   = 4'd7,
        HOLD    = 4'd8
    } state_t;

    state_t            state_r;
    logic              sel_r;
    logic [7:0]        n_r;
    logic [W-1:0]      a_r;
    logic [W-1:0]      b_r;
    logic [W-1:0]      c_r;
    logic [4*NDIG-1:0] bcd_r;
    logic [7:0]        cnt_r;
    logic [DW-1:0]     dig_r;
    logic [1:0]        kind_r;
    logic              last_r;

    logic [W:0]        sum_s;
    logic [4*NDIG-1:0] bcd_next_s;
    logic [3:0]        digit_s;
    logic [7:0]        byte_s;
    logic [W-1:0]      moser_bit_s;

    // One double-dabble step: add 3 to every digit >= 5, then shift in the next binary bit.
    function automatic logic [4*NDIG-1:0] dabble_fn(input logic [4*NDIG-1:0] v, input logic in_bit);
        logic [4*NDIG-1:0] r;
        r = v;
        for (int i = 0; i < NDIG; i++) begin
            if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
            else                     r[4*i +: 4] = v[4*i +: 4];
        end
        return {r[4*NDIG-2:0], in_bit};
    endfunction

    // Index of the most significant non-zero digit; 0 when the value is zero so "0" is still sent.
    function automatic logic [DW-1:0] lead_fn(input logic [4*NDIG-1:0] v);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (v[4*i +: 4] != 4'd0) r = DW'(i);
            else                     r = r;
        end
        return r;
    endfunction

    // Datapath helpers: Padovan adder with carry, BCD step, Moser bit placement and the next reply byte.
    always_comb begin
        sum_s       = {1'b0, a_r} + {1'b0, b_r};
        bcd_next_s  = dabble_fn(bcd_r, c_r[W-1]);
        moser_bit_s = W'(n_r[cnt_r[2:0]]) << {cnt_r[2:0], 1'b0};
        digit_s     = bcd_r[{dig_r, 2'b00} +: 4];
        byte_s      = 8'h0A;
        case (kind_r)
`ifdef SEQ_CTRL_PREFIX_EN
            K_PRE0:  byte_s = sel_r ? 8'h4D : 8'h50;
            K_PRE1:  byte_s = 8'h3D;
`endif
            K_BODY: begin
                if (ovf) begin
                    case (dig_r)
                        DW'(2):  byte_s = 8'h4F;
                        DW'(1):  byte_s = 8'h56;
                        default: byte_s = 8'h46;
                    endcase
                end else begin
                    byte_s = {4'h3, digit_s};
                end
            end
            K_NL:    byte_s = 8'h0A;
            default: byte_s = 8'h0A;
        endcase
    end

    // Main sequencer with registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            sel_r      <= 1'b0;
            n_r        <= 8'd0;
            a_r        <= '0;
            b_r        <= '0;
            c_r        <= '0;
            bcd_r      <= '0;
            cnt_r      <= 8'd0;
            dig_r      <= '0;
            kind_r     <= 2'd0;
            last_r     <= 1'b0;
            parser_clr <= 1'b0;
            tx_data    <= 8'd0;
            tx_start   <= 1'b0;
            busy       <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            tx_start   <= 1'b0;
            parser_clr <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (cmd_ready) begin
                        state_r <= LATCH;
                        busy    <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LATCH: begin
                    sel_r   <= seq_sel;
                    n_r     <= n_value;
                    ovf     <= 1'b0;
                    a_r     <= W'(1'b1);
                    b_r     <= W'(1'b1);
                    c_r     <= seq_sel ? '0 : W'(1'b1);
                    cnt_r   <= seq_sel ? 8'd0 : ((n_value >= 8'd3) ? (n_value - 8'd2) : 8'd1);
                    state_r <= CALC;
                end
                CALC: begin
                    if (sel_r) begin
                        c_r <= c_r | moser_bit_s;
                        if (cnt_r == 8'd7) begin
                            cnt_r   <= 8'(W - 1);
                            bcd_r   <= '0;
                            state_r <= BCD;
                        end else begin
                            cnt_r <= cnt_r + 8'd1;
                        end
                    end else if (n_r < 8'd3) begin
                        cnt_r   <= 8'(W - 1);
                        bcd_r   <= '0;
                        state_r <= BCD;
                    end else if (sum_s[W]) begin
                        // Carry out of the W-bit term: abandon the value and reply "OVF".
                        ovf     <= 1'b1;
                        dig_r   <= DW'(2);
                        kind_r  <= K_FIRST;
                        state_r <= EMIT;
                    end else begin
                        a_r <= b_r;
                        b_r <= c_r;
                        c_r <= sum_s[W-1:0];
                        if (cnt_r == 8'd1) begin
                            cnt_r   <= 8'(W - 1);
                            bcd_r   <= '0;
                            state_r <= BCD;
                        end else begin
                            cnt_r <= cnt_r - 8'd1;
                        end
                    end
                end
                BCD: begin
                    bcd_r <= bcd_next_s;
                    c_r   <= {c_r[W-2:0], 1'b0};
                    if (cnt_r == 8'd0) begin
                        dig_r   <= lead_fn(bcd_next_s);
                        kind_r  <= K_FIRST;
                        state_r <= EMIT;
                    end else begin
                        cnt_r <= cnt_r - 8'd1;
                    end
                end
                EMIT: begin
                    if (!tx_busy) begin
                        tx_data  <= byte_s;
                        tx_start <= 1'b1;
                        state_r  <= TXWAIT1;
                        case (kind_r)
`ifdef SEQ_CTRL_PREFIX_EN
                            K_PRE0: kind_r <= K_PRE1;
                            K_PRE1: kind_r <= K_BODY;
`endif
                            K_BODY: begin
                                if (dig_r == '0) kind_r <= K_NL;
                                else             dig_r  <= dig_r - DW'(1);
                            end
                            K_NL:    last_r <= 1'b1;
                            default: kind_r <= K_NL;
                        endcase
                    end else begin
                        state_r <= EMIT;
                    end
                end
                TXWAIT1: state_r <= TXWAIT;
                TXWAIT: begin
                    if (!tx_busy) begin
                        if (last_r) begin
                            last_r     <= 1'b0;
                            parser_clr <= 1'b1;
                            state_r    <= CLEAR;
                        end else begin
                            state_r <= EMIT;
                        end
                    end else begin
                        state_r <= TXWAIT;
                    end
                end
                CLEAR: state_r <= HOLD;
                HOLD: begin
                    if (!cmd_ready) begin
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        state_r <= HOLD;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_controller.sv
// Self-checking bench for seq_controller: string-level reply model, byte scoreboard and a 20-cycle UART TX stand-in.
module tb_seq_controller;
    localparam int W = 32;
    localparam longint MAXV = (longint'(1) << W) - 1;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       cmd_ready;
    logic       seq_sel;
    logic [7:0] n_value;
    logic       parser_clr;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       busy;
    logic       ovf;

    logic [4:0] busy_cnt = 5'd0;
    byte        exp_q[$];
    int         chk_n = 0;
    int         err_n = 0;
    int         tx_n  = 0;
    int         clr_n = 0;

    seq_controller #(.W(W), .NDIG(10)) dut (
        .clk(clk), .reset_n(reset_n), .cmd_ready(cmd_ready), .seq_sel(seq_sel),
        .n_value(n_value), .parser_clr(parser_clr), .tx_data(tx_data),
        .tx_start(tx_start), .tx_busy(tx_busy), .busy(busy), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // UART TX stand-in: busy for 20 cycles starting the cycle after tx_start.
    always @(posedge clk) begin
        if (busy_cnt != 5'd0) busy_cnt <= busy_cnt - 5'd1;
        else if (tx_start)    busy_cnt <= 5'd20;
    end
    assign tx_busy = (busy_cnt != 5'd0);

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        chk_n++;
        if (got !== want) begin
            err_n++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic string shown(input string s);
        string r;
        r = "";
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == 8'h0A) r = {r, "\\n"};
            else               r = $sformatf("%s%c", r, s[i]);
        end
        return r;
    endfunction

    task automatic check_str(input string name, input string got, input string want);
        chk_n++;
        if (got != want) begin
            err_n++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", name, shown(got), shown(want));
        end
    endtask

    function automatic string prefix(input bit sel);
`ifdef SEQ_CTRL_PREFIX_EN
        return sel ? "M=" : "P=";
`else
        return sel ? "" : "";
`endif
    endfunction

    // Reply straight from the sequence definitions; o reports whether the term exceeds W bits.
    function automatic string model_reply(input bit sel, input int n, output bit o);
        longint p [0:255];
        longint v;
        string  body;
        o = 1'b0;
        v = 0;
        if (sel) begin
            for (int i = 0; i < 8; i++) if (n[i]) v = v + (longint'(1) << (2 * i));
        end else begin
            for (int k = 0; k <= n && !o; k++) begin
                if (k < 3) p[k] = 1;
                else       p[k] = p[k-2] + p[k-3];
                if (p[k] > MAXV) o = 1'b1;
            end
            v = p[n];
        end
        body = o ? "OVF" : $sformatf("%0d", v);
        return {prefix(sel), body, "\n"};
    endfunction

    // Scoreboard: every transmitted byte and every clear pulse is checked on the falling edge.
    initial begin
        bit  clr_prev;
        byte b;
        clr_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (tx_start) begin
                    tx_n++;
                    check("tx_not_while_busy", 32'(tx_busy), 32'd0);
                    check("tx_busy_flag", 32'(busy), 32'd1);
                    if (exp_q.size() > 0) begin
                        b = exp_q.pop_front();
                        check("tx_byte", 32'(tx_data), 32'(b));
                    end else begin
                        check("tx_unexpected", 32'(tx_data), 32'hFFFF_FFFF);
                    end
                end
                if (parser_clr) begin
                    clr_n++;
                    check("clr_single_cycle", 32'(clr_prev), 32'd0);
                    check("clr_after_reply", 32'(exp_q.size()), 32'd0);
                end
                clr_prev = parser_clr;
            end else begin
                clr_prev = 1'b0;
            end
        end
    end

    task automatic run_cmd(input bit sel, input int n, input int hold);
        string s;
        bit    o;
        int    c0, t0, k;
        s = model_reply(sel, n, o);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        c0 = clr_n;
        t0 = tx_n;
        @(posedge clk); #1;
        seq_sel   = sel;
        n_value   = n[7:0];
        cmd_ready = 1'b1;
        k = 0;
        while (clr_n == c0 && k < 4000) begin
            @(posedge clk); #1;
            k++;
        end
        check("reply_done_in_time", 32'(clr_n != c0), 32'd1);
        for (int i = 0; i < hold; i++) @(posedge clk);
        #1;
        check("reply_len", 32'(tx_n - t0), 32'(s.len()));
        check("reply_left", 32'(exp_q.size()), 32'd0);
        check("busy_in_hold", 32'(busy), 32'd1);
        cmd_ready = 1'b0;
        k = 0;
        while (busy && k < 10) begin
            @(posedge clk); #1;
            k++;
        end
        check("idle_after", 32'(busy), 32'd0);
        check("clr_count", 32'(clr_n - c0), 32'd1);
        check("ovf_flag", 32'(ovf), 32'(o));
        exp_q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit    o;
        string s;
        int    t0, c0, k;
        reset_n   = 1'b0;
        cmd_ready = 1'b0;
        seq_sel   = 1'b0;
        n_value   = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 32'({tx_data, tx_start, parser_clr, busy, ovf}), 32'd0);
        reset_n = 1'b1;

        // Pin the model against hand-computed replies.
        s = model_reply(1'b0, 10, o);  check_str("model_P10", s, {prefix(1'b0), "12\n"});
        s = model_reply(1'b1, 5, o);   check_str("model_M5", s, {prefix(1'b1), "17\n"});
        s = model_reply(1'b1, 0, o);   check_str("model_M0", s, {prefix(1'b1), "0\n"});
        s = model_reply(1'b0, 0, o);   check_str("model_P0", s, {prefix(1'b0), "1\n"});
        s = model_reply(1'b1, 255, o); check_str("model_M255", s, {prefix(1'b1), "21845\n"});
        s = model_reply(1'b0, 99, o);  check_str("model_P99", s, {prefix(1'b0), "OVF\n"});
        check("model_P99_ovf", 32'(o), 32'd1);

        run_cmd(1'b0, 10, 0);
        run_cmd(1'b1, 5, 0);
        run_cmd(1'b1, 0, 0);
        run_cmd(1'b0, 0, 0);
        run_cmd(1'b0, 2, 0);
        run_cmd(1'b0, 3, 0);
        run_cmd(1'b0, 99, 5);
        run_cmd(1'b1, 255, 0);
        run_cmd(1'b0, 10, 60);

        // Reset while the reply is being sent: everything stops, no clear pulse follows.
        s = model_reply(1'b1, 255, o);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        t0 = tx_n;
        @(posedge clk); #1;
        seq_sel   = 1'b1;
        n_value   = 8'd255;
        cmd_ready = 1'b1;
        k = 0;
        while (!(tx_start && tx_n == t0 + 2) && k < 4000) begin
            @(posedge clk); #1;
            k++;
        end
        check("mid_reply_reached", 32'(tx_start && tx_n == t0 + 2), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_reset_outputs", 32'({tx_data, tx_start, parser_clr, busy, ovf}), 32'd0);
        exp_q.delete();
        cmd_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        t0 = tx_n;
        c0 = clr_n;
        repeat (100) @(posedge clk);
        #1;
        check("mid_no_tx", 32'(tx_n - t0), 32'd0);
        check("mid_no_clr", 32'(clr_n - c0), 32'd0);
        check("mid_idle", 32'(busy), 32'd0);

        run_cmd(1'b0, 10, 0);

        $display("CHECKS %0d ERRORS %0d", chk_n, err_n);
        $finish;
    end
endmodule
